exu_adder_arbiter: RTL
======================

// Module: exu_adder_arbiter
// PURPOSE
//  - Shares the single EXU universal adder between two requesters: port 0 = IDU/EXU ALU ops, port 1 = LSU address gen.
//  - Round-robin arbitration with valid/ready on request and response sides.
//  - Each port has one registered response slot.
//  - Drives the external adder combinationally and decodes add/sub/unsigned-cmp/signed-cmp results.
// PARAMETERS
//  DATAWIDTH    32  operand/result width; must match the adder instance
//  RR_INIT_LAST 1   reset value of last-granted pointer (1 => port 0 wins first tie)
// PORTS
//  clk          in   1          system clock, all state on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  req0_valid   in   1          port 0 request valid
//  req0_ready   out  1          port 0 request accepted this cycle
//  req0_a       in   DATAWIDTH  port 0 operand a
//  req0_b       in   DATAWIDTH  port 0 operand b
//  req0_op      in   2          00 add, 01 sub, 10 unsigned cmp, 11 signed cmp
//  rsp0_valid   out  1          port 0 result valid
//  rsp0_ready   in   1          port 0 consumer takes result
//  rsp0_data    out  DATAWIDTH  port 0 result
//  req1_*/rsp1_*     same as port 0, for port 1
//  adder_a      out  DATAWIDTH  shared adder operand a
//  adder_b      out  DATAWIDTH  shared adder operand b (already negated for sub/cmp)
//  adder_out    in   DATAWIDTH  shared adder sum, combinational from adder_a/adder_b
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - rsp0_valid = rsp1_valid = 0
//    - rsp0_data = rsp1_data = 0
//    - last-granted pointer = RR_INIT_LAST
//    - Any in-flight result is discarded.
//  - Eligibility: portN is eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1), i.e. its slot is free or drains this cycle.
//  - Grant: exactly one port per cycle.
//    - Only one eligible port: grant it.
//    - Both eligible: grant the port != last-granted pointer.
//    - The pointer updates only on a grant.
//  - reqN_ready = grantN; it depends combinationally on valid, rsp state and the pointer. No combinational path from reqN_valid of the other port beyond arbitration.
//  - Latency: 1 cycle. Result is registered into rspN_data at the grant edge; rspN_valid=1 the next cycle.
//  - Response slot:
//    - rspN_valid clears on rspN_ready=1 unless a new grant to port N reloads it in the same cycle (drain+refill => stays 1, new data).
//    - The slot holds data stable while rspN_valid=1 and rspN_ready=0.
//  - Adder drive (granted op):
//    - adder_a = a.
//    - adder_b = b for add; ~b + 1 for sub and cmp (wraps mod 2^DATAWIDTH).
//    - No grant: adder_a = adder_b = 0.
//  - Result decode, with s = adder_out and msb = DATAWIDTH-1:
//    - add/sub: data = s (overflow ignored, wraps).
//    - eq = (s == 0).
//    - ult = (~a[msb] & b[msb]) | (~(a[msb]^b[msb]) & s[msb]).
//    - slt = s[msb] ^ ((a[msb]^b[msb]) & (s[msb]^a[msb])).
//    - cmp result = 0 if eq; 4 (32'b100) if lt; 2 (32'b10) if gt (lt = ult for op 10, slt for op 11).
//  - b = 0 with sub/cmp: ~0 + 1 = 0, so a - 0 = a. No special case.
//  - Starvation bound: a continuously eligible port is granted within 2 cycles.
//  - Request operands need only be stable in the grant cycle. After reqN_ready=1 the requester may change them.
// CONFIGURATION
//  EXU_ARB_PERF_EN defined adds outputs:
//    - perf_grant0, perf_grant1 (32b): grant counts per port.
//    - perf_conflict (32b): cycles where both req valid and one was denied, whether for a full slot or the arbitration loss.
//    - Counters reset to 0 and wrap at 2^32.
//  EXU_ARB_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  - Single add:
//    - Stimulus: port0 valid, a=5, b=7, op=00.
//    - Response: req0_ready same cycle; next cycle rsp0_valid=1, data=12.
//  - Both ports valid every cycle with rsp_ready=1:
//    - Grants alternate 0,1,0,1 starting with port 0.
//    - Each port yields one result per 2 cycles.
//  - Compares:
//    - op=11, a=0xFFFFFFFF, b=1 -> 4 (signed lt).
//    - op=10, same operands -> 2 (unsigned gt).
//    - a=b=0x80000000 -> 0.
//  - Back-pressure:
//    - Stimulus: rsp1_ready=0 with rsp1 full; port1 valid; port0 valid.
//    - Response: port1 never granted, port0 granted each cycle, rsp1_data held.
//    - Then rsp1_ready=1: port1 drains and refills in the same cycle.
//  - Sub wrap: a=0, b=1, op=01 -> 0xFFFFFFFF. Overflow add 0xFFFFFFFF+1 -> 0.
//  - Reset mid-operation:
//    - Stimulus: rst_n low while rsp0_valid=1.
//    - Response: rsp0_valid drops asynchronously. After release, the first tie grants port 0.
//    - With EXU_ARB_PERF_EN, counters read 0.

Source files
------------

// File: rtl/exu_adder_arbiter_if.sv
// One requester's request/response channel to the shared EXU adder arbiter.
// master = requester side, slave = arbiter side.
interface exu_adder_arbiter_if #(
  parameter int DATAWIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [DATAWIDTH-1:0] req_a;
  logic [DATAWIDTH-1:0] req_b;
  logic [1:0]           req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATAWIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/exu_adder_arbiter.sv
// Round-robin sharing of the external EXU adder between the ALU (p0) and LSU address gen (p1),
// with one registered response slot per port. Optional perf counters: EXU_ARB_PERF_EN.
module exu_adder_arbiter #(
  parameter int DATAWIDTH    = 32,
  parameter bit RR_INIT_LAST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  exu_adder_arbiter_if.slave   p0,
  exu_adder_arbiter_if.slave   p1,
  output logic [DATAWIDTH-1:0] adder_a,
  output logic [DATAWIDTH-1:0] adder_b,
  input  logic [DATAWIDTH-1:0] adder_out
`ifdef EXU_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grant0,
  output logic [31:0]          perf_grant1,
  output logic [31:0]          perf_conflict
`endif
);
  localparam int MSB = DATAWIDTH - 1;

  logic [1:0]           w_req_valid;
  logic [1:0]           w_rsp_ready;
  logic [DATAWIDTH-1:0] w_req_a  [2];
  logic [DATAWIDTH-1:0] w_req_b  [2];
  logic [1:0]           w_req_op [2];
  logic [1:0]           w_elig;
  logic [1:0]           w_grant;

  logic                 r_last;
  logic [1:0]           r_rsp_valid;
  logic [DATAWIDTH-1:0] r_rsp_data [2];

  logic [DATAWIDTH-1:0] w_sel_a;
  logic [DATAWIDTH-1:0] w_sel_b;
  logic [1:0]           w_sel_op;
  logic                 w_negate;
  logic                 w_eq;
  logic                 w_ult;
  logic                 w_slt;
  logic                 w_lt;
  logic [DATAWIDTH-1:0] w_result;

  assign w_req_valid = {p1.req_valid, p0.req_valid};
  assign w_rsp_ready = {p1.rsp_ready, p0.rsp_ready};
  assign w_req_a[0]  = p0.req_a;
  assign w_req_a[1]  = p1.req_a;
  assign w_req_b[0]  = p0.req_b;
  assign w_req_b[1]  = p1.req_b;
  assign w_req_op[0] = p0.req_op;
  assign w_req_op[1] = p1.req_op;

  // A port competes only if its slot is empty or is being drained this cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign w_elig[gi]  = w_req_valid[gi] & (~r_rsp_valid[gi] | w_rsp_ready[gi]);
      assign w_grant[gi] = w_elig[gi] & (~w_elig[1-gi] | (r_last != 1'(gi)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rsp_valid[gi] <= 1'b0;
          r_rsp_data[gi]  <= '0;
        end else if (w_grant[gi]) begin
          r_rsp_valid[gi] <= 1'b1;
          r_rsp_data[gi]  <= w_result;
        end else if (w_rsp_ready[gi]) begin
          r_rsp_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= RR_INIT_LAST;
    end else if (|w_grant) begin
      r_last <= w_grant[1];
    end
  end

  // Idle cycles present zero operands so the shared adder does not toggle needlessly.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = 2'b00;
    if (w_grant[1]) begin
      w_sel_a  = w_req_a[1];
      w_sel_b  = w_req_b[1];
      w_sel_op = w_req_op[1];
    end else if (w_grant[0]) begin
      w_sel_a  = w_req_a[0];
      w_sel_b  = w_req_b[0];
      w_sel_op = w_req_op[0];
    end
  end

  assign w_negate = (w_sel_op != 2'b00);
  assign adder_a  = w_sel_a;
  assign adder_b  = w_negate ? (~w_sel_b + DATAWIDTH'(1)) : w_sel_b;

  // Compare flags derived from the sign bits and the a + (-b) sum.
  assign w_eq  = (adder_out == '0);
  assign w_ult = (~w_sel_a[MSB] & w_sel_b[MSB]) |
                 (~(w_sel_a[MSB] ^ w_sel_b[MSB]) & adder_out[MSB]);
  assign w_slt = adder_out[MSB] ^
                 ((w_sel_a[MSB] ^ w_sel_b[MSB]) & (adder_out[MSB] ^ w_sel_a[MSB]));
  assign w_lt  = w_sel_op[0] ? w_slt : w_ult;

  always_comb begin
    w_result = adder_out;
    if (w_sel_op[1]) begin
      if (w_eq) begin
        w_result = '0;
      end else if (w_lt) begin
        w_result = DATAWIDTH'(4);
      end else begin
        w_result = DATAWIDTH'(2);
      end
    end
  end

  assign p0.req_ready = w_grant[0];
  assign p1.req_ready = w_grant[1];
  assign p0.rsp_valid = r_rsp_valid[0];
  assign p1.rsp_valid = r_rsp_valid[1];
  assign p0.rsp_data  = r_rsp_data[0];
  assign p1.rsp_data  = r_rsp_data[1];

`ifdef EXU_ARB_PERF_EN
  logic [31:0] r_perf_grant0;
  logic [31:0] r_perf_grant1;
  logic [31:0] r_perf_conflict;

  // With both requesting, at most one is granted, so every such cycle denies someone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grant0   <= '0;
      r_perf_grant1   <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (w_grant[0])    r_perf_grant0   <= r_perf_grant0 + 32'd1;
      if (w_grant[1])    r_perf_grant1   <= r_perf_grant1 + 32'd1;
      if (&w_req_valid)  r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_grant0   = r_perf_grant0;
  assign perf_grant1   = r_perf_grant1;
  assign perf_conflict = r_perf_conflict;
`endif
endmodule
